// File: rtl/hyperbus_burst_ctrl_if.sv
// Bus bundle for hyperbus_burst_ctrl: command/TX/RX FIFO handshakes,
// Hyperbus native request/data signals, busy and sticky error status.
//   slave  : burst controller view (drives cmd_ready, tx_ready, rx_*,
//            hbus_*_o, hbus_rrq/wrq, busy, err_*)
//   master : environment view (FIFOs, Hyperbus controller, CSRs)
interface hyperbus_burst_ctrl_if #(
    parameter int FIFO_DATA_WIDTH = 32,
    parameter int HBUS_DATA_WIDTH = 16,
    parameter int HBUS_ADDR_WIDTH = 32,
    parameter int BURST_WIDTH     = 8
);
    logic                       cmd_valid;
    logic                       cmd_ready;
    logic                       cmd_write;
    logic [HBUS_ADDR_WIDTH-1:0] cmd_adr;
    logic [BURST_WIDTH-1:0]     cmd_len;

    logic                       tx_valid;
    logic                       tx_ready;
    logic [FIFO_DATA_WIDTH-1:0] tx_dat;

    logic                       rx_valid;
    logic                       rx_ready;
    logic [FIFO_DATA_WIDTH-1:0] rx_dat;

    logic [HBUS_ADDR_WIDTH-1:0] hbus_adr_o;
    logic [BURST_WIDTH+3:0]     hbus_len_o;
    logic                       hbus_rrq;
    logic                       hbus_wrq;
    logic [HBUS_DATA_WIDTH-1:0] hbus_dat_o;
    logic [HBUS_DATA_WIDTH-1:0] hbus_dat_i;
    logic                       hbus_ready;
    logic                       hbus_valid;
    logic                       hbus_busy;

    logic                       busy;
    logic                       err_overrun;
    logic                       err_underrun;
    logic                       err_clr;

    modport slave (
        input  cmd_valid, cmd_write, cmd_adr, cmd_len,
        output cmd_ready,
        input  tx_valid, tx_dat,
        output tx_ready,
        output rx_valid, rx_dat,
        input  rx_ready,
        output hbus_adr_o, hbus_len_o, hbus_rrq, hbus_wrq,
        output hbus_dat_o,
        input  hbus_dat_i, hbus_ready, hbus_valid, hbus_busy,
        output busy, err_overrun, err_underrun,
        input  err_clr
    );

    modport master (
        output cmd_valid, cmd_write, cmd_adr, cmd_len,
        input  cmd_ready,
        output tx_valid, tx_dat,
        input  tx_ready,
        input  rx_valid, rx_dat,
        output rx_ready,
        input  hbus_adr_o, hbus_len_o, hbus_rrq, hbus_wrq,
        input  hbus_dat_o,
        output hbus_dat_i, hbus_ready, hbus_valid, hbus_busy,
        input  busy, err_overrun, err_underrun,
        output err_clr
    );
endinterface

// File: rtl/hyperbus_burst_ctrl.sv
// Burst sequencer between the command/TX/RX FIFOs and the Hyperbus
// native interface: splits FIFO words into MSB-first beats on writes,
// reassembles beats into words on reads, sticky overrun/underrun flags.
// Ports: hbus_clk, hbus_rst (async, active-high), bus (slave modport:
// cmd_*, tx_*, rx_*, hbus_*, busy, err_overrun, err_underrun, err_clr).
module hyperbus_burst_ctrl #(
    parameter int FIFO_DATA_WIDTH = 32,
    parameter int HBUS_DATA_WIDTH = 16,
    parameter int HBUS_ADDR_WIDTH = 32,
    parameter int BURST_WIDTH     = 8
) (
    input logic                  hbus_clk,
    input logic                  hbus_rst,
    hyperbus_burst_ctrl_if.slave bus
);
    localparam int FW    = FIFO_DATA_WIDTH;
    localparam int HW    = HBUS_DATA_WIDTH;
    localparam int AW    = HBUS_ADDR_WIDTH;
    localparam int RATIO = FW / HW;
    localparam int BTW   = (RATIO > 1) ? $clog2(RATIO) : 1;
    localparam int LW    = BURST_WIDTH + 4;
    localparam int CW    = BURST_WIDTH + 1;

    localparam logic [BTW-1:0] LAST_BEAT = BTW'(RATIO - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WR   = 2'd1,
        RD   = 2'd2
    } state_t;

    state_t state_q;
    state_t state_d;

    logic [AW-1:0]          adr_q;
    logic [LW-1:0]          len_q;
    logic [LW-1:0]          len_calc;
    logic                   rrq_q;
    logic                   wrq_q;

    logic [BTW-1:0]         beat_q;
    logic [BURST_WIDTH-1:0] word_q;
    logic [CW-1:0]          fetch_q;

    logic [FW-1:0]          tx_shift_q;
    logic [FW-1:0]          tx_shift_sh;
    logic                   loaded_q;

    logic [FW-1:0]          asm_q;
    logic [FW-1:0]          asm_d;
    logic [FW-1:0]          rx_dat_q;
    logic                   rx_valid_q;

    logic                   err_over_q;
    logic                   err_under_q;

    logic cmd_ready;
    logic cmd_fire;
    logic tx_ready;
    logic tx_fire;
    logic last_beat;
    logic wr_beat;
    logic rd_beat;
    logic word_end;
    logic done;
    logic rx_take;
    logic rx_load;
    logic overrun_evt;
    logic underrun_evt;

    // Held low during reset so the FIFO never sees a handshake while the
    // block is being cleared.
    assign cmd_ready = !hbus_rst
                     && (state_q == IDLE)
                     && !bus.hbus_busy;
    assign cmd_fire  = cmd_ready && bus.cmd_valid;

    assign last_beat = (beat_q == LAST_BEAT);

    // Refill either an empty word register or one whose last beat leaves
    // this cycle, giving back-to-back words without a bubble.
    assign tx_ready = (state_q == WR)
                    && (fetch_q != '0)
                    && (!loaded_q || (bus.hbus_ready && last_beat));
    assign tx_fire  = tx_ready && bus.tx_valid;

    assign wr_beat      = (state_q == WR) && bus.hbus_ready && loaded_q;
    assign underrun_evt = (state_q == WR) && bus.hbus_ready && !loaded_q;
    assign rd_beat      = (state_q == RD) && bus.hbus_valid;

    assign word_end = (wr_beat || rd_beat) && last_beat;
    assign done     = word_end && (word_q == '0);

    assign rx_take     = rx_valid_q && bus.rx_ready;
    assign rx_load     = rd_beat && last_beat
                       && (!rx_valid_q || rx_take);
    assign overrun_evt = rd_beat && last_beat
                       && rx_valid_q && !rx_take;

    // Full-width beat count, cannot overflow for RATIO <= 16.
    assign len_calc = ({4'd0, bus.cmd_len} + LW'(1)) * LW'(RATIO)
                    - LW'(1);

    generate
        if (RATIO == 1) begin : g_single
            assign tx_shift_sh = '0;
            assign asm_d       = bus.hbus_dat_i;
        end else begin : g_multi
            assign tx_shift_sh = {tx_shift_q[FW-HW-1:0], {HW{1'b0}}};
            assign asm_d       = {asm_q[FW-HW-1:0], bus.hbus_dat_i};
        end
    endgenerate

    always_ff @(posedge hbus_clk or posedge hbus_rst) begin
        if (hbus_rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (cmd_fire) begin
                    state_d = bus.cmd_write ? WR : RD;
                end
            end
            WR, RD: begin
                if (done) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge hbus_clk or posedge hbus_rst) begin
        if (hbus_rst) begin
            adr_q  <= '0;
            len_q  <= '0;
            rrq_q  <= 1'b0;
            wrq_q  <= 1'b0;
            beat_q <= '0;
            word_q <= '0;
        end else begin
            rrq_q <= cmd_fire && !bus.cmd_write;
            wrq_q <= cmd_fire && bus.cmd_write;
            if (cmd_fire) begin
                adr_q  <= bus.cmd_adr;
                len_q  <= len_calc;
                word_q <= bus.cmd_len;
                beat_q <= '0;
            end else if (word_end) begin
                beat_q <= '0;
                word_q <= word_q - BURST_WIDTH'(1);
            end else if (wr_beat || rd_beat) begin
                beat_q <= beat_q + BTW'(1);
            end
        end
    end

    always_ff @(posedge hbus_clk or posedge hbus_rst) begin
        if (hbus_rst) begin
            tx_shift_q <= '0;
            loaded_q   <= 1'b0;
            fetch_q    <= '0;
        end else begin
            if (cmd_fire) begin
                fetch_q <= {1'b0, bus.cmd_len} + CW'(1);
            end
            if (tx_fire) begin
                tx_shift_q <= bus.tx_dat;
                loaded_q   <= 1'b1;
                fetch_q    <= fetch_q - CW'(1);
            end else if (wr_beat) begin
                tx_shift_q <= tx_shift_sh;
                if (last_beat) begin
                    loaded_q <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge hbus_clk or posedge hbus_rst) begin
        if (hbus_rst) begin
            asm_q      <= '0;
            rx_dat_q   <= '0;
            rx_valid_q <= 1'b0;
        end else begin
            if (rd_beat) begin
                asm_q <= asm_d;
            end
            if (rx_load) begin
                rx_dat_q   <= asm_d;
                rx_valid_q <= 1'b1;
            end else if (rx_take) begin
                rx_valid_q <= 1'b0;
            end
        end
    end

    // A new error event in the same cycle as err_clr keeps the flag set.
    always_ff @(posedge hbus_clk or posedge hbus_rst) begin
        if (hbus_rst) begin
            err_over_q  <= 1'b0;
            err_under_q <= 1'b0;
        end else begin
            err_over_q  <= overrun_evt
                        || (err_over_q && !bus.err_clr);
            err_under_q <= underrun_evt
                        || (err_under_q && !bus.err_clr);
        end
    end

    assign bus.cmd_ready    = cmd_ready;
    assign bus.tx_ready     = tx_ready;
    assign bus.rx_valid     = rx_valid_q;
    assign bus.rx_dat       = rx_dat_q;
    assign bus.hbus_adr_o   = adr_q;
    assign bus.hbus_len_o   = len_q;
    assign bus.hbus_rrq     = rrq_q;
    assign bus.hbus_wrq     = wrq_q;
    assign bus.hbus_dat_o   = tx_shift_q[FW-1 -: HW];
    assign bus.busy         = (state_q != IDLE);
    assign bus.err_overrun  = err_over_q;
    assign bus.err_underrun = err_under_q;

endmodule

// File: tb/tb_hyperbus_burst_ctrl.sv
// Self-checking bench for hyperbus_burst_ctrl: directed scenarios plus
// randomized bursts checked against a word/beat-level reference model.
module tb_hyperbus_burst_ctrl;
    localparam int FW = 32;
    localparam int HW = 16;
    localparam int AW = 32;
    localparam int BW = 8;
    localparam int R  = FW / HW;

    logic hbus_clk = 1'b0;
    logic hbus_rst = 1'b1;
    int   checks   = 0;
    int   errors   = 0;

    always #5 hbus_clk = ~hbus_clk;

    hyperbus_burst_ctrl_if #(
        .FIFO_DATA_WIDTH(FW),
        .HBUS_DATA_WIDTH(HW),
        .HBUS_ADDR_WIDTH(AW),
        .BURST_WIDTH(BW)
    ) bus ();

    hyperbus_burst_ctrl #(
        .FIFO_DATA_WIDTH(FW),
        .HBUS_DATA_WIDTH(HW),
        .HBUS_ADDR_WIDTH(AW),
        .BURST_WIDTH(BW)
    ) dut (
        .hbus_clk(hbus_clk),
        .hbus_rst(hbus_rst),
        .bus(bus)
    );

    task automatic chk(input string tag,
                       input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge hbus_clk);
        #1;
    endtask

    task automatic quiet();
        bus.cmd_valid  = 1'b0;
        bus.cmd_write  = 1'b0;
        bus.cmd_adr    = '0;
        bus.cmd_len    = '0;
        bus.tx_valid   = 1'b0;
        bus.tx_dat     = '0;
        bus.rx_ready   = 1'b0;
        bus.hbus_dat_i = '0;
        bus.hbus_ready = 1'b0;
        bus.hbus_valid = 1'b0;
        bus.hbus_busy  = 1'b0;
        bus.err_clr    = 1'b0;
    endtask

    task automatic issue(input logic wr,
                         input logic [AW-1:0] adr,
                         input logic [BW-1:0] len);
        bus.cmd_valid = 1'b1;
        bus.cmd_write = wr;
        bus.cmd_adr   = adr;
        bus.cmd_len   = len;
        #1;
        chk("cmd_ready_issue", bus.cmd_ready, 1);
        cyc();
        bus.cmd_valid = 1'b0;
    endtask

    task automatic clear_errs();
        bus.err_clr = 1'b1;
        cyc();
        bus.err_clr = 1'b0;
        #1;
        chk("err_ovr_clr", bus.err_overrun, 0);
        chk("err_und_clr", bus.err_underrun, 0);
    endtask

    task automatic drain();
        bus.rx_ready = 1'b1;
        cyc();
        bus.rx_ready = 1'b0;
        #1;
        chk("rx_drained", bus.rx_valid, 0);
    endtask

    // Write model: the word stream becomes an MSB-first beat stream; a beat
    // is available whenever more beats were fetched than consumed.
    task automatic run_write(input logic [BW-1:0] len,
                             input int rdy_pct,
                             input int val_pct);
        logic [FW-1:0] words[$];
        logic [HW-1:0] beats[$];
        logic [FW-1:0] w;
        logic [AW-1:0] adr;
        logic          exp_rdy;
        logic          exp_under;
        int total;
        int pushed;
        int consumed;
        int avail;
        int n;
        total     = int'(len) + 1;
        pushed    = 0;
        consumed  = 0;
        n         = 0;
        exp_under = 1'b0;
        adr       = $urandom;
        for (int i = 0; i < total; i++) begin
            w = $urandom;
            words.push_back(w);
            for (int k = 0; k < R; k++) begin
                beats.push_back(w[FW-1-k*HW -: HW]);
            end
        end
        issue(1'b1, adr, len);
        while (consumed < total * R && n < 3000) begin
            bus.hbus_ready = ($urandom_range(99) < rdy_pct);
            bus.tx_valid   = (pushed < total)
                           && ($urandom_range(99) < val_pct);
            bus.tx_dat     = (pushed < total) ? words[pushed] : $urandom;
            bus.hbus_valid = 1'($urandom_range(1));
            bus.hbus_dat_i = HW'($urandom);
            #1;
            if (n == 0) begin
                chk("wr_wrq", bus.hbus_wrq, 1);
                chk("wr_len", bus.hbus_len_o, total * R - 1);
                chk("wr_adr", bus.hbus_adr_o, adr);
            end else if (n == 1) begin
                chk("wr_wrq_once", bus.hbus_wrq, 0);
            end
            chk("wr_busy", bus.busy, 1);
            avail   = pushed * R - consumed;
            exp_rdy = (pushed < total)
                    && (avail == 0 || (bus.hbus_ready && avail == 1));
            chk("wr_tx_ready", bus.tx_ready, exp_rdy);
            if (bus.hbus_ready) begin
                if (avail > 0) begin
                    chk("wr_beat", bus.hbus_dat_o, beats[consumed]);
                    consumed++;
                end else begin
                    exp_under = 1'b1;
                end
            end
            if (bus.tx_valid && exp_rdy) pushed++;
            cyc();
            n++;
        end
        chk("wr_timeout", (n < 3000), 1);
        quiet();
        #1;
        chk("wr_idle", bus.busy, 0);
        chk("wr_underrun", bus.err_underrun, exp_under);
        chk("wr_no_ovr", bus.err_overrun, 0);
        chk("wr_cmd_ready", bus.cmd_ready, 1);
        clear_errs();
    endtask

    // Read model: every R beats form one word, first beat in the MSBs; the
    // single holding slot accepts a word if empty or drained this cycle.
    task automatic run_read(input logic [BW-1:0] len,
                            input int val_pct,
                            input int rr_pct);
        logic [FW-1:0] cur;
        logic [FW-1:0] hold_d;
        logic [AW-1:0] adr;
        logic          hold_v;
        logic          take;
        logic          exp_over;
        int total;
        int sent;
        int n;
        total    = int'(len) + 1;
        sent     = 0;
        n        = 0;
        cur      = '0;
        hold_d   = '0;
        hold_v   = 1'b0;
        exp_over = 1'b0;
        adr      = $urandom;
        issue(1'b0, adr, len);
        while (sent < total * R && n < 3000) begin
            bus.hbus_valid = ($urandom_range(99) < val_pct);
            bus.hbus_dat_i = HW'($urandom);
            bus.rx_ready   = ($urandom_range(99) < rr_pct);
            bus.hbus_ready = 1'($urandom_range(1));
            #1;
            if (n == 0) begin
                chk("rd_rrq", bus.hbus_rrq, 1);
                chk("rd_len", bus.hbus_len_o, total * R - 1);
                chk("rd_adr", bus.hbus_adr_o, adr);
            end else if (n == 1) begin
                chk("rd_rrq_once", bus.hbus_rrq, 0);
            end
            chk("rd_busy", bus.busy, 1);
            chk("rd_rx_valid", bus.rx_valid, hold_v);
            if (hold_v) chk("rd_rx_dat", bus.rx_dat, hold_d);
            take = hold_v && bus.rx_ready;
            if (bus.hbus_valid) begin
                cur = (cur << HW) | FW'(bus.hbus_dat_i);
                sent++;
            end
            if (bus.hbus_valid && (sent % R == 0)) begin
                if (!hold_v || take) begin
                    hold_v = 1'b1;
                    hold_d = cur;
                end else begin
                    exp_over = 1'b1;
                end
            end else if (take) begin
                hold_v = 1'b0;
            end
            cyc();
            n++;
        end
        chk("rd_timeout", (n < 3000), 1);
        quiet();
        #1;
        chk("rd_idle", bus.busy, 0);
        chk("rd_rx_valid_end", bus.rx_valid, hold_v);
        if (hold_v) chk("rd_rx_dat_end", bus.rx_dat, hold_d);
        chk("rd_overrun", bus.err_overrun, exp_over);
        chk("rd_no_under", bus.err_underrun, 0);
        if (hold_v) drain();
        clear_errs();
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        quiet();
        hbus_rst = 1'b1;
        cyc();
        cyc();
        chk("rst_cmd_ready", bus.cmd_ready, 0);
        chk("rst_tx_ready", bus.tx_ready, 0);
        chk("rst_rx_valid", bus.rx_valid, 0);
        chk("rst_rx_dat", bus.rx_dat, 0);
        chk("rst_adr", bus.hbus_adr_o, 0);
        chk("rst_len", bus.hbus_len_o, 0);
        chk("rst_rrq", bus.hbus_rrq, 0);
        chk("rst_wrq", bus.hbus_wrq, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_ovr", bus.err_overrun, 0);
        chk("rst_und", bus.err_underrun, 0);
        hbus_rst = 1'b0;
        #1;
        chk("rel_cmd_ready", bus.cmd_ready, 1);
        cyc();

        // Directed two-word write.
        issue(1'b1, 32'h100, 8'd1);
        bus.tx_valid = 1'b1;
        bus.tx_dat   = 32'hAABBCCDD;
        #1;
        chk("dw_wrq", bus.hbus_wrq, 1);
        chk("dw_len", bus.hbus_len_o, 3);
        chk("dw_adr", bus.hbus_adr_o, 32'h100);
        chk("dw_busy", bus.busy, 1);
        chk("dw_tx_ready0", bus.tx_ready, 1);
        cyc();
        bus.tx_valid   = 1'b0;
        bus.hbus_ready = 1'b1;
        #1;
        chk("dw_wrq_low", bus.hbus_wrq, 0);
        chk("dw_b0", bus.hbus_dat_o, 16'hAABB);
        chk("dw_tx_ready1", bus.tx_ready, 0);
        cyc();
        bus.tx_valid = 1'b1;
        bus.tx_dat   = 32'h11223344;
        #1;
        chk("dw_b1", bus.hbus_dat_o, 16'hCCDD);
        chk("dw_tx_ready2", bus.tx_ready, 1);
        cyc();
        bus.tx_valid = 1'b0;
        #1;
        chk("dw_b2", bus.hbus_dat_o, 16'h1122);
        chk("dw_tx_ready3", bus.tx_ready, 0);
        cyc();
        #1;
        chk("dw_b3", bus.hbus_dat_o, 16'h3344);
        chk("dw_busy3", bus.busy, 1);
        cyc();
        bus.hbus_ready = 1'b0;
        #1;
        chk("dw_done", bus.busy, 0);
        chk("dw_no_und", bus.err_underrun, 0);

        // Directed single-word read with held rx_valid.
        issue(1'b0, 32'h200, 8'd0);
        bus.hbus_valid = 1'b1;
        bus.hbus_dat_i = 16'h1234;
        #1;
        chk("dr_rrq", bus.hbus_rrq, 1);
        chk("dr_len", bus.hbus_len_o, 1);
        chk("dr_rx_valid0", bus.rx_valid, 0);
        cyc();
        bus.hbus_dat_i = 16'h5678;
        #1;
        chk("dr_rx_valid1", bus.rx_valid, 0);
        cyc();
        bus.hbus_valid = 1'b0;
        #1;
        chk("dr_rx_valid2", bus.rx_valid, 1);
        chk("dr_rx_dat", bus.rx_dat, 32'h12345678);
        chk("dr_busy", bus.busy, 0);
        cyc();
        cyc();
        chk("dr_hold", bus.rx_valid, 1);
        drain();

        // Read overrun.
        issue(1'b0, 32'h300, 8'd1);
        bus.hbus_valid = 1'b1;
        bus.hbus_dat_i = 16'hAAAA;
        cyc();
        bus.hbus_dat_i = 16'hBBBB;
        cyc();
        bus.hbus_dat_i = 16'hCCCC;
        #1;
        chk("ov_w0_valid", bus.rx_valid, 1);
        chk("ov_w0_dat", bus.rx_dat, 32'hAAAABBBB);
        chk("ov_none_yet", bus.err_overrun, 0);
        cyc();
        bus.hbus_dat_i = 16'hDDDD;
        cyc();
        bus.hbus_valid = 1'b0;
        #1;
        chk("ov_held", bus.rx_dat, 32'hAAAABBBB);
        chk("ov_flag", bus.err_overrun, 1);
        chk("ov_idle", bus.busy, 0);
        clear_errs();
        chk("ov_still_valid", bus.rx_valid, 1);
        drain();

        // Write underrun, then MSB slice still first.
        issue(1'b1, 32'h400, 8'd0);
        bus.hbus_ready = 1'b1;
        #1;
        chk("ur_tx_ready", bus.tx_ready, 1);
        chk("ur_none_yet", bus.err_underrun, 0);
        cyc();
        bus.hbus_ready = 1'b0;
        bus.tx_valid   = 1'b1;
        bus.tx_dat     = 32'hCAFEF00D;
        #1;
        chk("ur_flag", bus.err_underrun, 1);
        chk("ur_tx_ready2", bus.tx_ready, 1);
        cyc();
        bus.tx_valid   = 1'b0;
        bus.hbus_ready = 1'b1;
        #1;
        chk("ur_b0", bus.hbus_dat_o, 16'hCAFE);
        cyc();
        #1;
        chk("ur_b1", bus.hbus_dat_o, 16'hF00D);
        chk("ur_busy", bus.busy, 1);
        cyc();
        bus.hbus_ready = 1'b0;
        #1;
        chk("ur_done", bus.busy, 0);
        clear_errs();

        // Reset in the middle of a read.
        issue(1'b0, 32'h500, 8'd0);
        bus.hbus_valid = 1'b1;
        bus.hbus_dat_i = 16'h1111;
        cyc();
        bus.hbus_valid = 1'b0;
        hbus_rst = 1'b1;
        #1;
        chk("mr_rx_valid", bus.rx_valid, 0);
        chk("mr_busy", bus.busy, 0);
        chk("mr_cmd_ready", bus.cmd_ready, 0);
        cyc();
        hbus_rst = 1'b0;
        #1;
        chk("mr_rrq", bus.hbus_rrq, 0);
        chk("mr_cmd_ready2", bus.cmd_ready, 1);
        cyc();
        chk("mr_rrq2", bus.hbus_rrq, 0);
        issue(1'b0, 32'h600, 8'd0);
        bus.hbus_valid = 1'b1;
        bus.hbus_dat_i = 16'h2222;
        cyc();
        bus.hbus_dat_i = 16'h3333;
        cyc();
        bus.hbus_valid = 1'b0;
        #1;
        chk("mr_new_valid", bus.rx_valid, 1);
        chk("mr_new_dat", bus.rx_dat, 32'h22223333);
        drain();

        // Controller busy blocks acceptance.
        bus.hbus_busy = 1'b1;
        bus.cmd_valid = 1'b1;
        bus.cmd_write = 1'b0;
        bus.cmd_adr   = 32'h700;
        bus.cmd_len   = 8'd0;
        #1;
        chk("hb_ready0", bus.cmd_ready, 0);
        cyc();
        chk("hb_ready1", bus.cmd_ready, 0);
        chk("hb_rrq1", bus.hbus_rrq, 0);
        chk("hb_busy1", bus.busy, 0);
        cyc();
        chk("hb_rrq2", bus.hbus_rrq, 0);
        bus.hbus_busy = 1'b0;
        #1;
        chk("hb_ready2", bus.cmd_ready, 1);
        cyc();
        bus.cmd_valid  = 1'b0;
        bus.hbus_valid = 1'b1;
        bus.hbus_dat_i = 16'hABCD;
        #1;
        chk("hb_rrq3", bus.hbus_rrq, 1);
        chk("hb_adr", bus.hbus_adr_o, 32'h700);
        cyc();
        bus.hbus_dat_i = 16'hEF01;
        cyc();
        bus.hbus_valid = 1'b0;
        #1;
        chk("hb_rx_dat", bus.rx_dat, 32'hABCDEF01);
        drain();

        // Randomized bursts.
        for (int i = 0; i < 24; i++) begin
            if ($urandom_range(1) == 1) begin
                run_write(BW'($urandom_range(5)),
                          $urandom_range(30, 100),
                          $urandom_range(30, 100));
            end else begin
                run_read(BW'($urandom_range(5)),
                         $urandom_range(30, 100),
                         $urandom_range(0, 100));
            end
        end
        run_write(8'd255, 90, 90);
        run_read(8'd255, 90, 70);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/hyperbus_burst_ctrl.md
# hyperbus_burst_ctrl

Parametrised burst sequencer in the hbus_clk domain, between the clock-crossing command/TX/RX FIFOs and the Hyperbus native memory interface. It accepts one command per transaction, carrying R/W, address and burst length in FIFO words. It splits each FIFO_DATA_WIDTH word into FIFO_DATA_WIDTH/HBUS_DATA_WIDTH Hyperbus beats on writes and reassembles beats into words on reads. It supports multi-word bursts, prefetches TX data, backpressures RX through valid/ready, and reports sticky overrun and underrun errors.

## Interface
- FIFO_DATA_WIDTH, 32, user word width; must be an integer multiple of HBUS_DATA_WIDTH.
- HBUS_DATA_WIDTH, 16, Hyperbus beat width.
- HBUS_ADDR_WIDTH, 32, address width.
- BURST_WIDTH, 8, width of cmd_len; a burst is cmd_len+1 words (1..2^BURST_WIDTH).
- RATIO (localparam), FIFO_DATA_WIDTH/HBUS_DATA_WIDTH; 1..16 supported.
- hbus_clk  in  1  clock.
- hbus_rst  in  1  reset, asynchronous, active-high.
- cmd_valid / cmd_ready  in / out  1  command handshake.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_adr  in  HBUS_ADDR_WIDTH  start address.
- cmd_len  in  BURST_WIDTH  words minus one.
- tx_valid / tx_ready  in / out  1  TX word handshake; tx_dat  in  FIFO_DATA_WIDTH.
- rx_valid / rx_ready  out / in  1  RX word handshake; rx_dat  out  FIFO_DATA_WIDTH.
- hbus_adr_o  out  HBUS_ADDR_WIDTH  latched address.
- hbus_len_o  out  BURST_WIDTH+4  beats minus one, equal to (cmd_len+1)*RATIO-1.
- hbus_rrq / hbus_wrq  out  1  one-cycle request pulses.
- hbus_dat_o  out  HBUS_DATA_WIDTH  write beat; hbus_dat_i  in  HBUS_DATA_WIDTH  read beat.
- hbus_ready  in  1  controller consumes hbus_dat_o this cycle.
- hbus_valid  in  1  hbus_dat_i valid this cycle; cannot be stalled.
- hbus_busy  in  1  controller busy.
- busy  out  1  state != IDLE.
- err_overrun / err_underrun  out  1  sticky error flags.
- err_clr  in  1  clears both error flags.

## Operation
- States:
  - IDLE: cmd_ready = !hbus_busy. On cmd_valid&&cmd_ready, latch cmd_adr to hbus_adr_o, compute and latch hbus_len_o, load word counter = cmd_len, set beat index = 0. Go to WR if cmd_write, otherwise go to RD.
  - WR: runs until the final beat of the final word is consumed, then returns to IDLE.
  - RD: runs until the final word has been assembled, then returns to IDLE.
- Write path:
  - Word register tx_shift carries a loaded flag.
  - tx_ready = WR && words_to_fetch>0 && (!loaded || (hbus_ready && beat==RATIO-1)). This allows back-to-back words with no bubble.
  - hbus_dat_o = tx_shift[FW-1 -: HW], combinational. The most significant slice goes out first.
  - On hbus_ready && loaded: shift tx_shift left by HW and increment beat. At beat RATIO-1, clear loaded (unless reloaded the same cycle) and decrement the remaining word count.
  - On hbus_ready && !loaded: set err_underrun. No counter or shift change.
- Read path:
  - On hbus_valid: asm <= {asm[FW-HW-1:0], hbus_dat_i} and increment beat. The first beat lands in the MSBs.
  - On the RATIO-th beat the word is complete:
    - If !rx_valid, or rx_valid&&rx_ready this cycle, load rx_dat and set rx_valid.
    - Otherwise drop the word and set err_overrun.
  - rx_valid clears on rx_valid&&rx_ready when no new word is loaded.
  - The holding register drains independently of state. A new command may be accepted while rx_valid is high.
- Ignored inputs: hbus_valid in WR or IDLE; hbus_ready in RD or IDLE (no underrun raised outside WR).
- Error flags: err_clr clears both flags. If err_clr coincides with a new error event, set wins.
- Arithmetic: hbus_len_o is computed at full width with no truncation (RATIO ≤ 16). The word counter is BURST_WIDTH bits. The beat counter is max(1,$clog2(RATIO)) bits and wraps at RATIO-1. With RATIO=1, beat stays 0 and every beat completes a word.

## Timing
- Reset values: cmd_ready 0, tx_ready 0, rx_valid 0, rx_dat 0, hbus_adr_o 0, hbus_len_o 0, hbus_rrq/hbus_wrq 0, busy 0, err flags 0, state IDLE, loaded 0.
- After reset release, cmd_ready follows !hbus_busy from the first cycle.
- Command accepted at edge N: hbus_adr_o, hbus_len_o and busy are valid from N+1. hbus_wrq or hbus_rrq is high for exactly cycle N+1.
- The first tx_ready can assert in cycle N+1.
- Read latency: the edge that samples the RATIO-th hbus_valid beat registers rx_dat, so rx_valid is high from the next cycle.
- Write: the final beat is consumed at edge M; the block is in IDLE with busy=0 from M+1. cmd_ready also requires !hbus_busy.
- Reset asserted mid-burst: all outputs take their reset values immediately. In-flight words and partial assembly are discarded. No request pulse is issued after release.

## Test plan
- Write burst, RATIO=2, cmd_len=1, adr 0x100, tx 0xAABBCCDD then 0x11223344, hbus_ready held high:
  - hbus_wrq pulses once, hbus_len_o=3.
  - hbus_dat_o = 0xAABB, 0xCCDD, 0x1122, 0x3344 on consecutive cycles.
  - busy drops after the 4th beat.
- Read, cmd_len=0, hbus_dat_i 0x1234 then 0x5678 with hbus_valid:
  - rx_dat=0x12345678, rx_valid high the cycle after the second beat.
  - rx_valid held until rx_ready.
- Read overrun, cmd_len=1, rx_ready=0: first word held in rx_dat, second word dropped, err_overrun=1. err_clr pulse returns it to 0.
- Write underrun: tx_valid=0 while hbus_ready=1 in WR -> err_underrun=1, beat count unchanged. The next tx word still goes out MSB slice first.
- Reset mid-read after beat 1: rx_valid=0 and state IDLE immediately. The next read returns only new data.
- hbus_busy=1 with cmd_valid=1 -> cmd_ready=0 and no request pulse. Acceptance occurs the cycle hbus_busy falls.
